// File: rtl/doc_pkg.sv
// Shared constants and state encoding for the document RAM port arbiter.
package doc_pkg;
    localparam int               DOC_ADDR_W     = 9;
    localparam int               DOC_DATA_W     = 8;
    localparam int               DOC_DEPTH      = 512;
    localparam logic [7:0]       DOC_BLANK_CHAR = 8'h00;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_CLEAR = 1'b1
    } arb_state_t;
endpackage

// File: rtl/doc_port_arbiter_if.sv
// Requester and memory-port bundle between editor/messenger, arbiter and document RAM.
interface doc_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              clr_start;
    logic              clr_busy;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_spo;

    modport slave (
        input  clr_start, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_spo,
        output clr_busy, wr_gnt, rd_gnt, rd_valid, rd_data, mem_a, mem_d, mem_we
    );

    modport master (
        output clr_start, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_spo,
        input  clr_busy, wr_gnt, rd_gnt, rd_valid, rd_data, mem_a, mem_d, mem_we
    );
endinterface

// File: rtl/doc_clear_sweep.sv
// Clear engine: IDLE/CLEAR state, cell counter and busy flag for a full-document blank.
module doc_clear_sweep
    import doc_pkg::*;
#(
    parameter int ADDR_W = DOC_ADDR_W,
    parameter int DEPTH  = DOC_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_active,
    output logic [ADDR_W-1:0] o_addr
);
    // One extra counter bit so DEPTH == 2**ADDR_W still reaches its last index cleanly.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    arb_state_t      r_state;
    logic [ADDR_W:0] r_clr_cnt;
    logic            r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (i_start) begin
                        r_state   <= ARB_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ARB_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= ARB_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_active = r_busy;
    assign o_addr   = r_clr_cnt[ADDR_W-1:0];
endmodule

// File: rtl/doc_port_arbiter.sv
// Shares the document RAM read/write port between editor writes, messenger reads and the clear engine.
// Optional read anti-starvation is enabled by defining DOC_ARB_ANTI_STARVE_EN.
module doc_port_arbiter
    import doc_pkg::*;
#(
    parameter int ADDR_W = DOC_ADDR_W,
    parameter int DATA_W = DOC_DATA_W,
    parameter int DEPTH  = DOC_DEPTH,
`ifdef DOC_ARB_ANTI_STARVE_EN
    parameter int MAX_WAIT = 4,
`endif
    parameter logic [DATA_W-1:0] BLANK_CHAR = DOC_BLANK_CHAR
) (
    input  logic               clk,
    input  logic               rst,
    doc_port_arbiter_if.slave  bus
);
    logic              w_sweep_active;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_idle;
    logic              w_rd_force;
    logic              w_wr_gnt;
    logic              w_rd_gnt;

    logic [ADDR_W-1:0] r_mem_a;
    logic [DATA_W-1:0] r_mem_d;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    doc_clear_sweep #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sweep (
        .clk      (clk),
        .rst      (rst),
        .i_start  (bus.clr_start),
        .o_active (w_sweep_active),
        .o_addr   (w_sweep_addr)
    );

    // Grants are combinational, so gate them with rst to keep them low while reset is held.
    assign w_idle = !rst && !w_sweep_active;

`ifdef DOC_ARB_ANTI_STARVE_EN
    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait;

    assign w_rd_force = (r_wait >= WAIT_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (!w_sweep_active) begin
            if (!bus.rd_req || w_rd_gnt) begin
                r_wait <= '0;
            end else if (r_wait < WAIT_LIM) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end
`else
    assign w_rd_force = 1'b0;
`endif

    assign w_wr_gnt = w_idle && bus.wr_req && !(bus.rd_req && w_rd_force);
    assign w_rd_gnt = w_idle && bus.rd_req && (!bus.wr_req || w_rd_force);

    always_comb begin
        bus.mem_we = 1'b0;
        bus.mem_a  = r_mem_a;
        bus.mem_d  = r_mem_d;
        if (w_sweep_active) begin
            bus.mem_we = 1'b1;
            bus.mem_a  = w_sweep_addr;
            bus.mem_d  = BLANK_CHAR;
        end else if (w_wr_gnt) begin
            bus.mem_we = 1'b1;
            bus.mem_a  = bus.wr_addr;
            bus.mem_d  = bus.wr_data;
        end else if (w_rd_gnt) begin
            bus.mem_a  = bus.rd_addr;
        end
    end

    // The RAM read is asynchronous, so spo already reflects rd_addr in the grant cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_a    <= '0;
            r_mem_d    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_mem_a    <= bus.mem_a;
            r_mem_d    <= bus.mem_d;
            r_rd_valid <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_data <= bus.mem_spo;
            end
        end
    end

    assign bus.clr_busy = w_sweep_active;
    assign bus.wr_gnt   = w_wr_gnt;
    assign bus.rd_gnt   = w_rd_gnt;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
endmodule

// File: tb/tb_doc_port_arbiter.sv
// Directed bench for doc_port_arbiter with a behavioural document RAM on the memory port.
`timescale 1ns/1ps
module tb_doc_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int NV = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    doc_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    doc_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .DEPTH      (512),
        .BLANK_CHAR (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] ram [0:511];
    assign bus.mem_spo = ram[bus.mem_a];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_a] <= bus.mem_d;
    end

    typedef struct {
        logic          wr_req;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic          e_wr_gnt;
        logic          e_rd_gnt;
        logic          e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        logic          e_rv;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vt [NV];
    int   checks = 0;
    int   errors = 0;
    int   sw_n, sw_bad, sw_gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        while (!bus.wr_gnt && n < 1000) begin
            @(posedge clk); #1; @(negedge clk); n++;
        end
        chk("write_grant", 32'(bus.wr_gnt), 32'd1);
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
        $display("write addr=%h data=%h waited=%0d", a, d, n);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        int n = 0;
        bus.rd_req = 1'b1; bus.rd_addr = a;
        @(negedge clk);
        while (!bus.rd_gnt && n < 1000) begin
            @(posedge clk); #1; @(negedge clk); n++;
        end
        chk({name, "_grant"}, 32'(bus.rd_gnt), 32'd1);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({name, "_data"}, 32'(bus.rd_data), 32'(exp));
        $display("read addr=%h data=%h expect=%h", a, bus.rd_data, exp);
        @(posedge clk); #1;
    endtask

    // Pulse clr_start and follow the sweep; optional injections at given sweep cycles.
    task automatic run_clear(input int wr_at, input int rs_at, input int rst_at);
        bus.clr_start = 1'b1;
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        sw_n = 0; sw_bad = 0; sw_gnt = 0;
        while (bus.clr_busy && sw_n < 600) begin
            if (sw_n == wr_at) begin
                bus.wr_req = 1'b1; bus.wr_addr = 9'h0C8; bus.wr_data = 8'hAB;
            end
            bus.clr_start = (sw_n == rs_at);
            if (sw_n == rst_at) begin
                bus.wr_req = 1'b1; bus.wr_addr = 9'h0C8; bus.wr_data = 8'h5A;
                bus.rd_req = 1'b1; bus.rd_addr = 9'h032;
                #2 rst = 1'b1;
                #1;
                chk("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
                chk("rst_wr_gnt", 32'(bus.wr_gnt), 32'd0);
                chk("rst_rd_gnt", 32'(bus.rd_gnt), 32'd0);
                chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
                bus.wr_req = 1'b0; bus.rd_req = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            @(negedge clk);
            if (!bus.mem_we || bus.mem_a != 9'(sw_n) || bus.mem_d != 8'h00) sw_bad++;
            if (bus.wr_gnt || bus.rd_gnt) sw_gnt++;
            sw_n++;
            @(posedge clk); #1;
        end
        bus.clr_start = 1'b0;
        $display("clear swept=%0d bad_cells=%0d grants_during=%0d", sw_n, sw_bad, sw_gnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rd, n_rd, n_wr, wr_after;

        // wr_req, wr_addr, wr_data, rd_req, rd_addr | wr_gnt, rd_gnt, we, a, d, rd_valid, rd_data
        vt[0]  = '{1'b1, 9'h023, 8'h41, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h023, 8'h41, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h023, 8'h00, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 9'h000, 8'h00, 1'b1, 9'h023, 1'b0, 1'b1, 1'b0, 9'h023, 8'h00, 1'b0, 8'h00};
        vt[3]  = '{1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h023, 8'h00, 1'b1, 8'h41};
        vt[4]  = '{1'b1, 9'h010, 8'h11, 1'b1, 9'h011, 1'b1, 1'b0, 1'b1, 9'h010, 8'h11, 1'b0, 8'h41};
        vt[5]  = '{1'b1, 9'h011, 8'h22, 1'b1, 9'h011, 1'b1, 1'b0, 1'b1, 9'h011, 8'h22, 1'b0, 8'h41};
        vt[6]  = '{1'b1, 9'h012, 8'h33, 1'b1, 9'h011, 1'b1, 1'b0, 1'b1, 9'h012, 8'h33, 1'b0, 8'h41};
        vt[7]  = '{1'b0, 9'h000, 8'h00, 1'b1, 9'h011, 1'b0, 1'b1, 1'b0, 9'h011, 8'h00, 1'b0, 8'h41};
        vt[8]  = '{1'b0, 9'h000, 8'h00, 1'b1, 9'h010, 1'b0, 1'b1, 1'b0, 9'h010, 8'h00, 1'b1, 8'h22};
        vt[9]  = '{1'b0, 9'h000, 8'h00, 1'b1, 9'h012, 1'b0, 1'b1, 1'b0, 9'h012, 8'h00, 1'b1, 8'h11};
        vt[10] = '{1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h012, 8'h00, 1'b1, 8'h33};
        vt[11] = '{1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h012, 8'h00, 1'b0, 8'h33};

        rst = 1'b1;
        bus.clr_start = 1'b0;
        bus.wr_req = 1'b1; bus.wr_addr = 9'h023; bus.wr_data = 8'h41;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        #12;
        chk("reset_wr_gnt", 32'(bus.wr_gnt), 32'd0);
        chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset_mem_a", 32'(bus.mem_a), 32'd0);
        chk("reset_clr_busy", 32'(bus.clr_busy), 32'd0);
        chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        bus.wr_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus.wr_req  = vt[i].wr_req;  bus.wr_addr = vt[i].wr_addr; bus.wr_data = vt[i].wr_data;
            bus.rd_req  = vt[i].rd_req;  bus.rd_addr = vt[i].rd_addr;
            @(negedge clk);
            chk($sformatf("v%0d_wr_gnt", i), 32'(bus.wr_gnt), 32'(vt[i].e_wr_gnt));
            chk($sformatf("v%0d_rd_gnt", i), 32'(bus.rd_gnt), 32'(vt[i].e_rd_gnt));
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vt[i].e_we));
            chk($sformatf("v%0d_mem_a", i), 32'(bus.mem_a), 32'(vt[i].e_a));
            if (vt[i].e_we) chk($sformatf("v%0d_mem_d", i), 32'(bus.mem_d), 32'(vt[i].e_d));
            chk($sformatf("v%0d_rd_valid", i), 32'(bus.rd_valid), 32'(vt[i].e_rv));
            chk($sformatf("v%0d_rd_data", i), 32'(bus.rd_data), 32'(vt[i].e_rdata));
            $display("vec %0d wr_gnt=%b rd_gnt=%b we=%b a=%h rv=%b rdata=%h",
                     i, bus.wr_gnt, bus.rd_gnt, bus.mem_we, bus.mem_a, bus.rd_valid, bus.rd_data);
            @(posedge clk); #1;
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;

        // Plain full clear.
        run_clear(-1, -1, -1);
        chk("clear_len", 32'(sw_n), 32'd512);
        chk("clear_cells", 32'(sw_bad), 32'd0);
        chk("clear_no_grant", 32'(sw_gnt), 32'd0);
        chk("clear_busy_end", 32'(bus.clr_busy), 32'd0);
        do_read(9'h023, 8'h00, "post_clear_rd");

        // Write arrives mid-clear, plus an ignored restart pulse.
        run_clear(10, 20, -1);
        chk("clear2_len", 32'(sw_n), 32'd512);
        chk("clear2_cells", 32'(sw_bad), 32'd0);
        chk("clear2_no_grant", 32'(sw_gnt), 32'd0);
        @(negedge clk);
        chk("pending_wr_gnt", 32'(bus.wr_gnt), 32'd1);
        chk("pending_wr_a", 32'(bus.mem_a), 32'h0C8);
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
        do_write(9'h032, 8'hCD);
        do_read(9'h0C8, 8'hAB, "cell200_rd");

        // Reset in the middle of a sweep.
        run_clear(-1, -1, 100);
        chk("abort_len", 32'(sw_n), 32'd100);
        chk("abort_cells", 32'(sw_bad), 32'd0);
        chk("abort_busy", 32'(bus.clr_busy), 32'd0);
        do_read(9'h0C8, 8'hAB, "abort_cell200");
        do_read(9'h032, 8'h00, "abort_cell50");

        // Write and read contend continuously.
        bus.wr_req = 1'b1; bus.wr_addr = 9'h1F0; bus.wr_data = 8'h77;
        bus.rd_req = 1'b1; bus.rd_addr = 9'h023;
        first_rd = -1; n_rd = 0; n_wr = 0; wr_after = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (first_rd >= 0 && c == first_rd + 1) wr_after = 32'(bus.wr_gnt);
            if (bus.rd_gnt) begin
                n_rd++;
                if (first_rd < 0) first_rd = c;
            end
            if (bus.wr_gnt) n_wr++;
            $display("contend cycle %0d wr_gnt=%b rd_gnt=%b", c, bus.wr_gnt, bus.rd_gnt);
            @(posedge clk); #1;
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
`ifdef DOC_ARB_ANTI_STARVE_EN
        chk("starve_first_rd", 32'(first_rd), 32'd4);
        chk("starve_wr_resume", 32'(wr_after), 32'd1);
        chk("starve_rd_count", 32'(n_rd), 32'd2);
        chk("starve_wr_count", 32'(n_wr), 32'd10);
`else
        chk("strict_rd_count", 32'(n_rd), 32'd0);
        chk("strict_wr_count", 32'(n_wr), 32'd12);
`endif
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
